msi_request_dispatcher: RTL and testbench

//  Consumes the per-clock stimulus vector {address, op, processor, data} from the test-sequence generator.

---
 rtl/msi_request_dispatcher_if.sv | 36 +++
 rtl/msi_request_dispatcher.sv | 126 ++++++++++++
 tb/tb_msi_request_dispatcher.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msi_request_dispatcher_if.sv
// Request/stimulus bundle between the test-sequence generator, the dispatcher and the two L1 caches.
// master = dispatcher side, slave = generator/cache side.
interface msi_request_dispatcher_if #(
   parameter int CNT_W = 8
);
   logic [3:0]       address_in;
   logic [1:0]       wr_rd_in;
   logic [1:0]       processor_in;
   logic [3:0]       data_in;
   logic             req0_valid;
   logic             req0_ready;
   logic             req0_done;
   logic             req1_valid;
   logic             req1_ready;
   logic             req1_done;
   logic [3:0]       req_addr;
   logic             req_write;
   logic [3:0]       req_data;
   logic             busy;
   logic             overflow;
   logic [CNT_W-1:0] drop_count;

   modport master (
      input  address_in, wr_rd_in, processor_in, data_in,
      input  req0_ready, req0_done, req1_ready, req1_done,
      output req0_valid, req1_valid, req_addr, req_write, req_data,
      output busy, overflow, drop_count
   );

   modport slave (
      output address_in, wr_rd_in, processor_in, data_in,
      output req0_ready, req0_done, req1_ready, req1_done,
      input  req0_valid, req1_valid, req_addr, req_write, req_data,
      input  busy, overflow, drop_count
   );
endinterface

// File: rtl/msi_request_dispatcher.sv
// Buffers valid stimulus vectors in program order and issues them one at a time
// to the P0,0 / P0,1 L1 controllers with a valid/ready/done handshake.
module msi_request_dispatcher #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input logic                        i_clk,
   input logic                        i_rst_n,
   msi_request_dispatcher_if.master   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   // Entry layout: [9] processor, [8] write, [7:4] address, [3:0] data
   logic [9:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   state_t           r_state;
   logic             r_target;
   logic             r_req0_valid;
   logic             r_req1_valid;
   logic [3:0]       r_req_addr;
   logic             r_req_write;
   logic [3:0]       r_req_data;
   logic             r_overflow;
   logic [CNT_W-1:0] r_drop_count;

   logic       w_in_valid;
   logic       w_pop;
   logic       w_push;
   logic       w_drop;
   logic       w_tgt_ready;
   logic       w_tgt_done;
   logic [9:0] w_head;

   assign w_in_valid  = (bus.address_in != 4'd0) && !bus.wr_rd_in[1] && !bus.processor_in[1];
   assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
   // A full FIFO still accepts when the head leaves on the same edge.
   assign w_push      = w_in_valid && ((r_count != C_FULL) || w_pop);
   assign w_drop      = w_in_valid && !w_push;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_tgt_ready = r_target ? bus.req1_ready : bus.req0_ready;
   assign w_tgt_done  = r_target ? bus.req1_done  : bus.req0_done;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.processor_in[0], bus.wr_rd_in[0], bus.address_in, bus.data_in};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_target     <= 1'b0;
         r_req0_valid <= 1'b0;
         r_req1_valid <= 1'b0;
         r_req_addr   <= 4'd0;
         r_req_write  <= 1'b0;
         r_req_data   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_req_addr   <= w_head[7:4];
                  r_req_write  <= w_head[8];
                  r_req_data   <= w_head[3:0];
                  r_target     <= w_head[9];
                  r_req0_valid <= !w_head[9];
                  r_req1_valid <= w_head[9];
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_tgt_ready) begin
                  r_req0_valid <= 1'b0;
                  r_req1_valid <= 1'b0;
                  r_state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Only the target's Done ends the transaction; the other cache is ignored.
               if (w_tgt_done) r_state <= S_IDLE;
            end
            default: begin
               r_req0_valid <= 1'b0;
               r_req1_valid <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req0_valid = r_req0_valid;
   assign bus.req1_valid = r_req1_valid;
   assign bus.req_addr   = r_req_addr;
   assign bus.req_write  = r_req_write;
   assign bus.req_data   = r_req_data;
   assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
   assign bus.overflow   = r_overflow;
   assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_msi_request_dispatcher.sv
// Directed bench for msi_request_dispatcher: drives stimulus on negedge and models both L1 caches.
module tb_msi_request_dispatcher;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic       tgt;
      logic [3:0] addr;
      logic       wr;
      logic [3:0] data;
   } iss_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   bit   pend0 = 0, pend1 = 0;
   bit   auto_done0 = 1, auto_done1 = 1;
   bit   force_done0 = 0, force_done1 = 0;
   iss_t log_q[$];

   msi_request_dispatcher_if #(.CNT_W(8)) bus ();

   msi_request_dispatcher #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Cache model: logs each accept and pulses Done on the cycle after it.
   always @(negedge clk) begin
      #1;
      bus.req0_done = pend0 | force_done0;
      bus.req1_done = pend1 | force_done1;
      pend0 = 0;
      pend1 = 0;
      if (rst_n) begin
         if (bus.req0_valid && bus.req0_ready) begin
            log_q.push_back({1'b0, bus.req_addr, bus.req_write, bus.req_data});
            pend0 = auto_done0;
         end
         if (bus.req1_valid && bus.req1_ready) begin
            log_q.push_back({1'b1, bus.req_addr, bus.req_write, bus.req_data});
            pend1 = auto_done1;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   function automatic iss_t mk(input logic t, input logic [3:0] a, input logic w, input logic [3:0] d);
      return {t, a, w, d};
   endfunction

   // Read data is a don't-care, so only writes have their data compared.
   function automatic bit same_issue(input iss_t got, input iss_t exp);
      return (got.tgt === exp.tgt) && (got.addr === exp.addr) && (got.wr === exp.wr) &&
             (!exp.wr || (got.data === exp.data));
   endfunction

   task automatic drive(input logic [3:0] a, input logic [1:0] op, input logic [1:0] p, input logic [3:0] d);
      @(negedge clk);
      bus.address_in   = a;
      bus.wr_rd_in     = op;
      bus.processor_in = p;
      bus.data_in      = d;
   endtask

   task automatic drive_idle();
      drive(4'd0, 2'd0, 2'd0, 4'd0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      bus.address_in = 0; bus.wr_rd_in = 0; bus.processor_in = 0; bus.data_in = 0;
      bus.req0_ready = 0; bus.req1_ready = 0;
      force_done0 = 0; force_done1 = 0; auto_done0 = 1; auto_done1 = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      log_q.delete();
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!bus.busy) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset_state();
      bus.address_in = 0; bus.wr_rd_in = 0; bus.processor_in = 0; bus.data_in = 0;
      bus.req0_ready = 0; bus.req1_ready = 0;
      @(negedge clk);
      checks++;
      if ({bus.req0_valid, bus.req1_valid, bus.req_write, bus.busy, bus.overflow} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 00000",
                  {bus.req0_valid, bus.req1_valid, bus.req_write, bus.busy, bus.overflow});
      end
      checks++;
      if ({bus.req_addr, bus.req_data, bus.drop_count} !== 16'h0) begin
         errors++;
         $display("FAIL reset_payload: got %h, required 0000", {bus.req_addr, bus.req_data, bus.drop_count});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      reset_dut();
      bus.req0_ready = 1;
      drive(4'h1, 2'b00, 2'b00, 4'h5);
      drive_idle();
      checks++;
      if (bus.busy !== 1'b1 || bus.req0_valid !== 1'b0) begin
         errors++;
         $display("FAIL t2_latency1: got busy=%b v0=%b, required busy=1 v0=0", bus.busy, bus.req0_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.req0_valid !== 1'b1 || bus.req1_valid !== 1'b0 || bus.req_addr !== 4'h1 || bus.req_write !== 1'b0) begin
         errors++;
         $display("FAIL t2_issue: got v0=%b v1=%b addr=%h wr=%b, required v0=1 v1=0 addr=1 wr=0",
                  bus.req0_valid, bus.req1_valid, bus.req_addr, bus.req_write);
      end
      @(negedge clk);
      checks++;
      if (bus.req0_valid !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL t2_wait: got v0=%b busy=%b, required v0=0 busy=1", bus.req0_valid, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || log_q.size() != 1) begin
         errors++;
         $display("FAIL t2_done: got busy=%b issues=%0d, required busy=0 issues=1", bus.busy, log_q.size());
      end
   endtask

   task automatic test_ordering();
      iss_t exp_q[6];
      bit   ok;
      exp_q[0] = mk(0, 4'h1, 0, 4'h0);
      exp_q[1] = mk(0, 4'h6, 0, 4'h0);
      exp_q[2] = mk(0, 4'h6, 1, 4'h7);
      exp_q[3] = mk(0, 4'h5, 0, 4'h0);
      exp_q[4] = mk(1, 4'h5, 0, 4'h0);
      exp_q[5] = mk(1, 4'h5, 1, 4'h8);
      reset_dut();
      bus.req0_ready = 1; bus.req1_ready = 1;
      for (int i = 0; i < 6; i++) drive(exp_q[i].addr, {1'b0, exp_q[i].wr}, {1'b0, exp_q[i].tgt}, exp_q[i].data);
      drive_idle();
      wait_idle(ok);
      checks++;
      if (!ok || log_q.size() != 6) begin
         errors++;
         $display("FAIL t3_count: got idle=%0d issues=%0d, required idle=1 issues=6", ok, log_q.size());
      end
      for (int i = 0; i < 6 && i < log_q.size(); i++) begin
         checks++;
         if (!same_issue(log_q[i], exp_q[i])) begin
            errors++;
            $display("FAIL t3_issue[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_filtering();
      iss_t exp_q[3];
      bit   ok;
      exp_q[0] = mk(0, 4'h2, 0, 4'h0);
      exp_q[1] = mk(1, 4'h4, 1, 4'h9);
      exp_q[2] = mk(1, 4'h7, 0, 4'h0);
      reset_dut();
      bus.req0_ready = 1; bus.req1_ready = 1;
      drive(4'h2, 2'b00, 2'b00, 4'h0);
      drive(4'h0, 2'b01, 2'b00, 4'h3);
      drive(4'h3, 2'b10, 2'b00, 4'h0);
      drive(4'h4, 2'b01, 2'b01, 4'h9);
      drive(4'h5, 2'b00, 2'b11, 4'h0);
      drive(4'h6, 2'b11, 2'b10, 4'h0);
      drive(4'h7, 2'b00, 2'b01, 4'h0);
      drive_idle();
      wait_idle(ok);
      checks++;
      if (!ok || log_q.size() != 3) begin
         errors++;
         $display("FAIL t4_count: got idle=%0d issues=%0d, required idle=1 issues=3", ok, log_q.size());
      end
      for (int i = 0; i < 3 && i < log_q.size(); i++) begin
         checks++;
         if (!same_issue(log_q[i], exp_q[i])) begin
            errors++;
            $display("FAIL t4_issue[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
         end
      end
      checks++;
      if (bus.drop_count !== 8'd0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL t4_drops: got drop=%0d ovf=%b, required drop=0 ovf=0", bus.drop_count, bus.overflow);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      reset_dut();
      for (int i = 1; i <= DEPTH + 3; i++) drive(4'(i), 2'b01, 2'b00, ~4'(i));
      drive_idle();
      checks++;
      if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd2) begin
         errors++;
         $display("FAIL t5_drops: got ovf=%b drop=%0d, required ovf=1 drop=2", bus.overflow, bus.drop_count);
      end
      checks++;
      if (bus.req0_valid !== 1'b1 || bus.req_addr !== 4'h1) begin
         errors++;
         $display("FAIL t5_head: got v0=%b addr=%h, required v0=1 addr=1", bus.req0_valid, bus.req_addr);
      end
      bus.req0_ready = 1;
      wait_idle(ok);
      checks++;
      if (!ok || log_q.size() != DEPTH + 1) begin
         errors++;
         $display("FAIL t5_count: got idle=%0d issues=%0d, required idle=1 issues=%0d", ok, log_q.size(), DEPTH + 1);
      end
      for (int i = 0; i < DEPTH + 1 && i < log_q.size(); i++) begin
         checks++;
         if (!same_issue(log_q[i], mk(0, 4'(i + 1), 1, ~4'(i + 1)))) begin
            errors++;
            $display("FAIL t5_issue[%0d]: got %h, required %h", i, log_q[i], mk(0, 4'(i + 1), 1, ~4'(i + 1)));
         end
      end
      checks++;
      if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd2) begin
         errors++;
         $display("FAIL t5_sticky: got ovf=%b drop=%0d, required ovf=1 drop=2", bus.overflow, bus.drop_count);
      end
   endtask

   task automatic test_handshake_edges();
      iss_t exp_q[10];
      bit   ok;
      exp_q[0] = mk(0, 4'hA, 0, 4'h0);
      exp_q[1] = mk(1, 4'h4, 0, 4'h0);
      for (int i = 1; i <= 7; i++) exp_q[i + 1] = mk(0, 4'(i), 1, 4'(i));
      exp_q[9] = mk(0, 4'h9, 1, 4'h9);
      reset_dut();
      bus.req1_ready = 1;
      auto_done0 = 0;
      drive(4'hA, 2'b00, 2'b00, 4'h0);
      drive(4'h4, 2'b00, 2'b01, 4'h0);
      drive_idle();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.req0_valid !== 1'b1 || bus.req1_valid !== 1'b0 || bus.req_addr !== 4'hA) begin
         errors++;
         $display("FAIL t6_ready1_ignored: got v0=%b v1=%b addr=%h, required v0=1 v1=0 addr=a",
                  bus.req0_valid, bus.req1_valid, bus.req_addr);
      end
      @(negedge clk); force_done1 = 1;
      @(negedge clk); force_done1 = 0;
      @(negedge clk);
      checks++;
      if (bus.req0_valid !== 1'b1) begin
         errors++;
         $display("FAIL t6_done1_in_issue: got v0=%b, required v0=1", bus.req0_valid);
      end
      bus.req0_ready = 1;
      @(negedge clk); bus.req0_ready = 0;
      @(negedge clk);
      checks++;
      if (bus.req0_valid !== 1'b0 || bus.req1_valid !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL t6_wait: got v0=%b v1=%b busy=%b, required v0=0 v1=0 busy=1",
                  bus.req0_valid, bus.req1_valid, bus.busy);
      end
      force_done1 = 1;
      @(negedge clk); force_done1 = 0;
      @(negedge clk);
      checks++;
      if (bus.req1_valid !== 1'b0) begin
         errors++;
         $display("FAIL t6_done1_in_wait: got v1=%b, required v1=0", bus.req1_valid);
      end
      for (int i = 1; i <= 7; i++) drive(4'(i), 2'b01, 2'b00, 4'(i));
      drive_idle();
      force_done0 = 1;
      drive(4'h9, 2'b01, 2'b00, 4'h9);
      force_done0 = 0;
      drive_idle();
      checks++;
      if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
         errors++;
         $display("FAIL t6_push_on_pop: got ovf=%b drop=%0d, required ovf=0 drop=0", bus.overflow, bus.drop_count);
      end
      checks++;
      if (bus.req1_valid !== 1'b1 || bus.req_addr !== 4'h4) begin
         errors++;
         $display("FAIL t6_next_head: got v1=%b addr=%h, required v1=1 addr=4", bus.req1_valid, bus.req_addr);
      end
      auto_done0 = 1;
      bus.req0_ready = 1;
      wait_idle(ok);
      checks++;
      if (!ok || log_q.size() != 10) begin
         errors++;
         $display("FAIL t6_count: got idle=%0d issues=%0d, required idle=1 issues=10", ok, log_q.size());
      end
      for (int i = 0; i < 10 && i < log_q.size(); i++) begin
         checks++;
         if (!same_issue(log_q[i], exp_q[i])) begin
            errors++;
            $display("FAIL t6_issue[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_transaction();
      reset_dut();
      for (int i = 1; i <= DEPTH + 1; i++) drive(4'(i), 2'b01, 2'b00, 4'hF);
      drive_idle();
      @(negedge clk);
      checks++;
      if (bus.req0_valid !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL t1_pre: got v0=%b busy=%b, required v0=1 busy=1", bus.req0_valid, bus.busy);
      end
      rst_n = 1'b0;
      force_done0 = 1;
      #1;
      checks++;
      if ({bus.req0_valid, bus.req1_valid, bus.req_write, bus.busy, bus.overflow} !== 5'b0 ||
          {bus.req_addr, bus.req_data, bus.drop_count} !== 16'h0) begin
         errors++;
         $display("FAIL t1_async: got flags=%b payload=%h, required 00000 / 0000",
                  {bus.req0_valid, bus.req1_valid, bus.req_write, bus.busy, bus.overflow},
                  {bus.req_addr, bus.req_data, bus.drop_count});
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.req0_ready = 1;
      @(negedge clk);
      force_done0 = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.req0_valid !== 1'b0 || log_q.size() != 0) begin
         errors++;
         $display("FAIL t1_after: got busy=%b v0=%b issues=%0d, required busy=0 v0=0 issues=0",
                  bus.busy, bus.req0_valid, log_q.size());
      end
   endtask

   initial begin
      bus.req0_done = 0;
      bus.req1_done = 0;
      test_reset_state();
      test_single_read();
      test_ordering();
      test_filtering();
      test_overflow();
      test_handshake_edges();
      test_reset_mid_transaction();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
